// File: rtl/shift_receiver.sv
// LSB-first serial-to-parallel receiver with a one-word output holding register.
// Word appears one cycle after its last bit; Ack frees the register, a lost word sets sticky Overrun.
module shift_receiver #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Abort,
  input  logic             Shift_En,
  input  logic             Serial_In,
  input  logic             Ack,
  output logic [WIDTH-1:0] Data_Out,
  output logic             Data_Valid,
  output logic             Busy,
  output logic             Overrun
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              vld_q, vld_d;
  logic              ovr_q, ovr_d;
  logic [WIDTH-1:0]  word;

  assign word = {Serial_In, shift_q[WIDTH-1:1]};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    vld_d   = vld_q;
    ovr_d   = ovr_q;

    if (Ack && vld_q) begin
      vld_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (Start && !Abort) begin
          state_d = RECV;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      RECV: begin
        if (Abort) begin
          state_d = IDLE;
        end else if (Shift_En) begin
          shift_d = word;
          if (cnt_q == LAST) begin
            state_d = IDLE;
            // A held word survives unless the consumer takes it this same cycle.
            if (!vld_q || Ack) begin
              data_d = word;
              vld_d  = 1'b1;
            end else begin
              ovr_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Data_Out   = data_q;
  assign Data_Valid = vld_q;
  assign Busy       = (state_q == RECV);
  assign Overrun    = ovr_q;

endmodule

// File: tb/tb_shift_receiver.sv
// Directed bench for shift_receiver (WIDTH=8) with hand-computed expectations.
module tb_shift_receiver;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic       Abort = 1'b0;
  logic       Shift_En = 1'b0;
  logic       Serial_In = 1'b0;
  logic       Ack = 1'b0;
  logic [7:0] Data_Out;
  logic       Data_Valid;
  logic       Busy;
  logic       Overrun;

  int n_checks = 0;
  int n_fail   = 0;

  shift_receiver #(.WIDTH(8)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Abort      (Abort),
    .Shift_En   (Shift_En),
    .Serial_In  (Serial_In),
    .Ack        (Ack),
    .Data_Out   (Data_Out),
    .Data_Valid (Data_Valid),
    .Busy       (Busy),
    .Overrun    (Overrun)
  );

  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] d, input logic v,
                           input logic b, input logic o);
    check({tag, "_data"}, 32'(Data_Out), 32'(d));
    check({tag, "_valid"}, 32'(Data_Valid), 32'(v));
    check({tag, "_busy"}, 32'(Busy), 32'(b));
    check({tag, "_ovr"}, 32'(Overrun), 32'(o));
  endtask

  task automatic send_bit(input logic b);
    Shift_En  = 1'b1;
    Serial_In = b;
    tick;
    Shift_En  = 1'b0;
    Serial_In = 1'b0;
  endtask

  task automatic start_frame;
    Start = 1'b1;
    tick;
    Start = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] w, input int nb);
    for (int i = 0; i < nb; i++) send_bit(w[i]);
  endtask

  task automatic recv_word(input logic [7:0] w);
    start_frame();
    send_bits(w, 8);
  endtask

  task automatic do_ack;
    Ack = 1'b1;
    tick;
    Ack = 1'b0;
  endtask

  task automatic pulse_reset;
    #1 Reset = 1'b1;
    #1 check_out("reset_pulse", 8'h00, 1'b0, 1'b0, 1'b0);
    tick;
    Reset = 1'b0;
  endtask

  logic [7:0] pat;
  logic [7:0] sh;

  initial begin
    // Asynchronous reset before any clock edge.
    #2 Reset = 1'b1;
    #1 check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    tick;
    Reset = 1'b0;

    // Shift_En is ignored while idle.
    Shift_En = 1'b1; Serial_In = 1'b1;
    tick; tick;
    Shift_En = 1'b0; Serial_In = 1'b0;
    check_out("idle_shift", 8'h00, 1'b0, 1'b0, 1'b0);

    // Basic word 0xA5, one-cycle latency after the 8th bit.
    pat = 8'hA5;
    start_frame();
    check("basic_busy", 32'(Busy), 32'd1);
    send_bits(pat, 7);
    check("basic_valid_early", 32'(Data_Valid), 32'd0);
    send_bit(pat[7]);
    check_out("basic", 8'hA5, 1'b1, 1'b0, 1'b0);

    do_ack();
    check_out("ack", 8'hA5, 1'b0, 1'b0, 1'b0);
    do_ack();
    check_out("ack_idle", 8'hA5, 1'b0, 1'b0, 1'b0);

    // Gaps of 0-3 idle cycles between bits; a Start mid-frame is ignored.
    sh = 8'h00;
    start_frame();
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < i % 4; g++) begin
        if (i == 2 && g == 0) Start = 1'b1;
        tick;
        Start = 1'b0;
        check("gap_cnt", 32'(dut.cnt_q), 32'(i));
        check("gap_shift", 32'(dut.shift_q), 32'(sh));
      end
      send_bit(pat[i]);
      sh = {pat[i], sh[7:1]};
    end
    check_out("gaps", 8'hA5, 1'b1, 1'b0, 1'b0);
    do_ack();

    // Overrun: second word lost while the first is unacknowledged.
    recv_word(8'h3C);
    check_out("ovr_first", 8'h3C, 1'b1, 1'b0, 1'b0);
    recv_word(8'hFF);
    check_out("ovr_second", 8'h3C, 1'b1, 1'b0, 1'b1);
    do_ack();
    check_out("ovr_sticky", 8'h3C, 1'b0, 1'b0, 1'b1);

    pulse_reset();

    // Ack on the completing cycle lets the new word replace the old.
    recv_word(8'h3C);
    pat = 8'h81;
    start_frame();
    send_bits(pat, 7);
    Ack = 1'b1;
    send_bit(pat[7]);
    Ack = 1'b0;
    check_out("ack_cmpl", 8'h81, 1'b1, 1'b0, 1'b0);
    do_ack();

    // Abort after 5 bits leaves the outputs alone.
    pat = 8'h0F;
    start_frame();
    send_bits(8'hF0, 5);
    Abort = 1'b1;
    tick;
    Abort = 1'b0;
    check_out("abort", 8'h81, 1'b0, 1'b0, 1'b0);

    // Abort wins over a completing bit.
    start_frame();
    send_bits(8'hF0, 7);
    Abort = 1'b1;
    send_bit(1'b1);
    Abort = 1'b0;
    check_out("abort_cmpl", 8'h81, 1'b0, 1'b0, 1'b0);

    // Abort wins over Start in idle.
    Start = 1'b1; Abort = 1'b1;
    tick;
    Start = 1'b0; Abort = 1'b0;
    check("abort_start_busy", 32'(Busy), 32'd0);

    recv_word(pat);
    check_out("after_abort", 8'h0F, 1'b1, 1'b0, 1'b0);

    // Reset mid-frame clears everything before the next edge.
    start_frame();
    send_bits(8'hFF, 3);
    #2 Reset = 1'b1;
    #1 check_out("reset_mid", 8'h00, 1'b0, 1'b0, 1'b0);
    #2 Reset = 1'b0;
    recv_word(8'h55);
    check_out("after_reset", 8'h55, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_receiver.md
SHIFT_RECEIVER -- requirements
Module: shift_receiver

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, meaning the word length in bits (legal range 2 to 32).
REQ-002 The block SHALL have the port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have the port Start, input, 1 bit: begins a receive frame when the block is idle.
REQ-005 The block SHALL have the port Abort, input, 1 bit: discards the partial frame and returns the block to idle.
REQ-006 The block SHALL have the port Shift_En, input, 1 bit: Serial_In holds a valid bit this cycle.
REQ-007 The block SHALL have the port Serial_In, input, 1 bit: serial data, LSB first.
REQ-008 The block SHALL have the port Ack, input, 1 bit: the consumer has taken Data_Out.
REQ-009 The block SHALL have the port Data_Out, output, WIDTH bits: the last completed word.
REQ-010 The block SHALL have the port Data_Valid, output, 1 bit: Data_Out holds an unacknowledged word.
REQ-011 The block SHALL have the port Busy, output, 1 bit: a frame is in progress.
REQ-012 The block SHALL have the port Overrun, output, 1 bit: sticky flag set when a completed word is lost.

Function
REQ-013 The block SHALL implement a state machine with two states, IDLE and RECV.
REQ-014 In IDLE, Start=1 SHALL move the block to RECV at the next edge, clear the bit counter to 0, and clear the shift register to 0.
REQ-015 In IDLE, Shift_En SHALL be ignored.
REQ-016 In RECV, each cycle with Shift_En=1 SHALL update the shift register to {Serial_In, shift[WIDTH-1:1]} and increment the bit counter.
REQ-017 In RECV, a cycle with Shift_En=0 SHALL hold the shift register and the counter.
REQ-018 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL never wrap within a frame.
REQ-019 The cycle in which Shift_En=1 and counter=WIDTH-1 SHALL be the completing cycle.
REQ-020 At the completing cycle's edge, the block SHALL load {Serial_In, shift[WIDTH-1:1]} into Data_Out, set Data_Valid=1, and return to IDLE.
REQ-021 Latency from the last serial bit to Data_Valid=1 SHALL be 1 cycle.
REQ-022 Busy SHALL equal 1 exactly when the state is RECV.
REQ-023 Start asserted while in RECV SHALL be ignored.
REQ-024 Abort=1 in RECV SHALL return the block to IDLE at the next edge, discard the partial word, and leave Data_Out, Data_Valid and Overrun unchanged.
REQ-025 Abort SHALL take priority over a completing Shift_En in the same cycle, so no word is delivered.
REQ-026 Abort in IDLE SHALL have no effect, and Abort takes priority over Start when both are asserted.
REQ-027 Ack=1 with Data_Valid=1 and no completion in the same cycle SHALL clear Data_Valid at the next edge, with Data_Out holding its value.
REQ-028 Ack=1 while Data_Valid=0 SHALL be ignored.
REQ-029 On completion with Data_Valid=1 and Ack=0, the block SHALL drop the new word, hold Data_Out, keep Data_Valid=1, and set Overrun=1.
REQ-030 On completion with Data_Valid=1 and Ack=1 in the same cycle, the block SHALL load the new word into Data_Out, keep Data_Valid=1, and leave Overrun unchanged.
REQ-031 Overrun SHALL remain set until Reset; no other input clears it.
REQ-032 Start in the same cycle as the completing edge SHALL be ignored, because the block is in RECV during that cycle.

Reset
REQ-033 While Reset=1, state SHALL be IDLE, and the counter, shift register and Data_Out SHALL be 0.
REQ-034 While Reset=1, Data_Valid, Busy and Overrun SHALL be 0.
REQ-035 Reset SHALL act immediately, without waiting for a Clk edge, including in the middle of a frame; the partial word is lost.
REQ-036 After Reset deasserts, the block SHALL accept Start at the first rising edge.

Verification
REQ-037 Scenario "basic word": Start, then 8 consecutive Shift_En with bits 1,0,1,0,0,1,0,1 -> Data_Out=0xA5 and Data_Valid=1 one cycle after the 8th bit; Busy=0.
REQ-038 Scenario "gaps": the same 0xA5 sequence with Shift_En=0 gaps of 0-3 cycles between bits -> Data_Out=0xA5; counter and shift register held during the gaps.
REQ-039 Scenario "overrun": receive 0x3C with no Ack, then receive 0xFF -> Data_Out=0x3C, Data_Valid=1, Overrun=1.
REQ-040 Scenario "ack on completion": Data_Valid=1 holding 0x3C, with Ack=1 on the completing cycle of 0x81 -> Data_Out=0x81, Data_Valid=1, Overrun=0.
REQ-041 Scenario "abort": Abort after 5 bits of a frame, then a full frame of 0x0F -> Data_Out=0x0F; no output change at the abort.
REQ-042 Scenario "reset mid-frame": assert Reset asynchronously after 3 bits -> all outputs 0 before the next Clk edge; the next full frame of 0x55 -> Data_Out=0x55.
